mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Multi-requester arbiter for the single-port, byte-wide unified memory (`simple_memory`, synchronous read, one-cycle read latency). It lets the fetch unit, the execution unit and a host/debug loader share the memory concurrently, replacing the top-level state-based mux. Arbitration is round-robin, with an optional burst lock and a bounded lock length. Read data is steered back to the requester that issued the read.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, memory address width
- `DATA_WIDTH`, 8, memory data width
- `NUM_REQ`, 3, number of requesters (index 0 fetch, 1 exec, 2 host)
- `MAX_BURST`, 16, maximum consecutive locked grants before forced rotation (≥1)

Ports:
- `clk`  in  1  clock; all logic is rising-edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_i`  in  NUM_REQ  per-requester access request
- `we_i`  in  NUM_REQ  per-requester write enable (valid with req)
- `lock_i`  in  NUM_REQ  keep the grant for the next access (burst)
- `addr_i`  in  NUM_REQ×ADDR_WIDTH  per-requester address (unpacked array)
- `wdata_i`  in  NUM_REQ×DATA_WIDTH  per-requester write data (unpacked array)
- `gnt_o`  out  NUM_REQ  one-hot access accepted this cycle
- `rvalid_o`  out  NUM_REQ  one-hot; read data valid for that requester
- `rdata_o`  out  DATA_WIDTH  read data, broadcast; qualified by rvalid_o
- `mem_we`  out  1  to memory
- `mem_addr`  out  ADDR_WIDTH  to memory
- `mem_wdata`  out  DATA_WIDTH  to memory
- `mem_rdata`  in  DATA_WIDTH  from memory (valid one cycle after address)
- `owner_o`  out  $clog2(NUM_REQ)  requester granted in the last accepted access

## Operation
- One access per cycle at most. `gnt_o[k]` is combinational from `req_i` and the current state. The access is complete when `req_i[k] && gnt_o[k]`, with no further handshake.
- While `gnt_o[k]` is high, `mem_addr`, `mem_we` and `mem_wdata` carry requester k's values. With no grant, `mem_we=0`, `mem_addr=0` and `mem_wdata=0`.
- FSM states (`arb_state_t`):
  - **ARB_RR**: grant the first requesting index at or after `rr_ptr`, wrapping modulo NUM_REQ. On a grant to k: `rr_ptr <= (k+1) mod NUM_REQ`. If `lock_i[k]` is also high, go to ARB_LOCK with `lock_owner <= k` and `burst_cnt <= 1`.
  - **ARB_LOCK**:
    - Only `lock_owner` may be granted.
    - On a grant, `burst_cnt` increments.
    - Return to ARB_RR when any of the following holds:
      - the granted access has `lock_i=0`;
      - `req_i[lock_owner]=0` for a cycle, which releases the lock with no grant that cycle, so other requesters proceed the following cycle;
      - `burst_cnt==MAX_BURST` and another `req_i` bit is set (forced rotation).
    - If no other requester is pending, the burst continues past MAX_BURST with the counter saturated.
- Read return:
  - A registered one-hot `rd_pending`, set from `gnt_o & ~we_i`, drives `rvalid_o` in the next cycle.
  - `rdata_o = mem_rdata`, passed through combinationally.
  - A write never produces rvalid.
- Back-to-back reads from different requesters are legal. rvalid follows each grant one cycle later, in grant order.
- Simultaneous requests from all three requesters with `rr_ptr=0` are granted 0, 1, 2 in successive cycles, provided each holds its request.
- `owner_o` updates on each accepted access. It holds its value when idle.

## Timing
- Grant latency: 0 cycles (same cycle as the request) when the requester wins.
- Read data: `rvalid_o` and `rdata_o` arrive exactly 1 cycle after the granted read.
- Requesters must hold `req/we/addr/wdata` stable until granted.
- Reset (asynchronous, active-low):
  - Values: state ARB_RR, `rr_ptr=0`, `burst_cnt=0`, `rd_pending=0`, `owner_o=0`.
  - All outputs are 0 while `rst_n=0`. `gnt_o` is forced to 0 during reset.
  - Reset mid-burst or mid-read drops the pending rvalid. No rvalid is issued after reset release.
- Worst-case wait for a non-locking requester: (NUM_REQ−1)×MAX_BURST cycles.

## Structure
- Shared package `tinyml_mem_pkg`, containing:
  - `arb_state_t` (ARB_RR, ARB_LOCK)
  - requester index constants `REQ_FETCH=0`, `REQ_EXEC=1`, `REQ_HOST=2`
- Sub-module `rr_priority_picker`: combinational; inputs `req` and `ptr`, outputs a one-hot grant and its index. It is reused by the arbiter's RR state.
- The top-level integration connects `fetch_unit` and `modular_execution_unit` to indices 0 and 1. Their `mem_valid` inputs take `rvalid_o[k]`.

## Test plan
- **Reset:** assert `rst_n=0` with all `req_i=3'b111`.
  - Expect `gnt_o=0`, `rvalid_o=0` and `mem_we=0`.
  - After release, the first grant goes to index 0.
- **Read return:** host writes 0x5A to addr 0x0100; fetch then reads 0x0100.
  - Expect `rvalid_o=3'b001` one cycle after the fetch grant, with `rdata_o=0x5A`.
  - Expect no rvalid for the write.
- **Round-robin:** all three requesters hold reads continuously.
  - Expect the grant sequence 0, 1, 2, 0, 1, 2.
  - Expect each rvalid to match the previous cycle's grant.
- **Lock and forced rotation:** with `MAX_BURST=4`, exec holds lock and requests continuously while fetch requests.
  - Expect exec granted 4 consecutive cycles, then fetch granted once, then exec resumes.
- **Lock without competition:** exec bursts 20 locked accesses with no other requests.
  - Expect all 20 granted consecutively; `burst_cnt` saturates.
- **Lock release by dropping req:** exec holds a lock and then drops `req_i` for one cycle.
  - Expect the state to return to ARB_RR.
  - Expect a pending host request to be granted the next cycle.

Source files
------------

// File: rtl/tinyml_mem_pkg.sv
// Shared types and requester indices for the unified-memory port arbiter.
package tinyml_mem_pkg;

    typedef enum logic [0:0] {
        ARB_RR   = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_EXEC  = 1;
    localparam int unsigned REQ_HOST  = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping modulo N.
module rr_priority_picker #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int unsigned j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j[IDX_W-1:0]]) begin
                found               = 1'b1;
                gnt[j[IDX_W-1:0]]   = 1'b1;
                idx                 = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with bounded burst lock for the single-port unified
// memory; read data is steered back to the requester that issued the read.
module mem_port_arbiter
    import tinyml_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    input  logic [ADDR_WIDTH-1:0]      addr_i  [NUM_REQ],
    input  logic [DATA_WIDTH-1:0]      wdata_i [NUM_REQ],
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   lock_owner, lock_owner_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [NUM_REQ-1:0] rd_pending;
    logic [IDX_W-1:0]   owner_q;

    logic [NUM_REQ-1:0] owner_mask, others_req, pick_req, pick_gnt, gnt;
    logic [IDX_W-1:0]   pick_idx, gnt_idx;
    logic               pick_found, force_rot, rr_mode, gnt_any;

    always_comb begin
        owner_mask = NUM_REQ'(1) << lock_owner;
        others_req = req_i & ~owner_mask;
        pick_req   = (state == ARB_LOCK) ? others_req : req_i;
        force_rot  = (state == ARB_LOCK) && req_i[lock_owner] &&
                     (burst_cnt == CNT_W'(MAX_BURST)) && (|others_req);
    end

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // A forced rotation arbitrates the same cycle among the other requesters,
    // so the lock owner gets exactly MAX_BURST back-to-back grants.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_owner_nxt = lock_owner;
        burst_cnt_nxt  = burst_cnt;
        gnt            = '0;
        gnt_idx        = lock_owner;
        rr_mode        = 1'b0;

        case (state)
            ARB_RR: rr_mode = 1'b1;
            ARB_LOCK: begin
                if (!req_i[lock_owner]) begin
                    state_nxt = ARB_RR;
                end else if (force_rot) begin
                    rr_mode = 1'b1;
                end else begin
                    gnt = owner_mask;
                    if (burst_cnt != CNT_W'(MAX_BURST)) burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    if (!lock_i[lock_owner]) state_nxt = ARB_RR;
                end
            end
            default: state_nxt = ARB_RR;
        endcase

        if (rr_mode) begin
            state_nxt = ARB_RR;
            if (pick_found) begin
                gnt        = pick_gnt;
                gnt_idx    = pick_idx;
                rr_ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                if (lock_i[pick_idx]) begin
                    state_nxt      = ARB_LOCK;
                    lock_owner_nxt = pick_idx;
                    burst_cnt_nxt  = CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        gnt_o     = rst_n ? gnt : '0;
        gnt_any   = |gnt_o;
        mem_we    = gnt_any & we_i[gnt_idx];
        mem_addr  = gnt_any ? addr_i[gnt_idx] : '0;
        mem_wdata = gnt_any ? wdata_i[gnt_idx] : '0;
        rvalid_o  = rd_pending;
        rdata_o   = rst_n ? mem_rdata : '0;
        owner_o   = owner_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_RR;
            rr_ptr     <= '0;
            lock_owner <= '0;
            burst_cnt  <= '0;
            rd_pending <= '0;
            owner_q    <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock_owner <= lock_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
            rd_pending <= gnt_o & ~we_i;
            if (gnt_any) owner_q <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural arbitration/memory model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_mem_port_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_i, we_i, lock_i;
    logic [15:0] addr_i  [3];
    logic [7:0]  wdata_i [3];
    logic [2:0]  gnt_o, rvalid_o;
    logic [7:0]  rdata_o;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [1:0]  owner_o;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .NUM_REQ    (3),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .we_i      (we_i),
        .lock_i    (lock_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner_o   (owner_o)
    );

    always #5 clk = ~clk;

    // simple_memory stand-in: synchronous read, one-cycle latency
    logic [7:0] mem [65536];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int start);
        for (int i = 0; i < 3; i++) begin
            int j;
            j = (start + i) % 3;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Model state, expressed directly in terms of the arbitration rules
    logic [7:0] mm [65536];
    bit         m_locked;
    int         m_owner, m_cnt, m_ptr, m_own_out;
    logic [2:0] m_rv, m_last_gnt, m_eg, m_ob;
    logic [7:0] m_rv_data;
    int         m_win;
    bit         m_from_rr;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_owner", owner_o, 0);
            m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_own_out = 0;
            m_rv = '0; m_last_gnt = '0;
        end else begin
            chk("rvalid", rvalid_o, m_rv);
            if (m_rv != 0) chk("rdata", rdata_o, m_rv_data);
            chk("owner", owner_o, m_own_out);

            m_win = -1; m_from_rr = 0;
            if (m_locked) begin
                m_ob = 3'(1 << m_owner);
                if (!req_i[m_owner]) begin
                    m_locked = 0;
                end else if (m_cnt >= MB && (req_i & ~m_ob) != 0) begin
                    m_locked = 0; m_from_rr = 1;
                    m_win = pick(req_i & ~m_ob, m_ptr);
                end else begin
                    m_win = m_owner;
                    if (m_cnt < MB) m_cnt++;
                    if (!lock_i[m_win]) m_locked = 0;
                end
            end else begin
                m_from_rr = 1;
                m_win = pick(req_i, m_ptr);
            end
            if (m_from_rr && m_win >= 0) begin
                m_ptr = (m_win + 1) % 3;
                if (lock_i[m_win]) begin m_locked = 1; m_owner = m_win; m_cnt = 1; end
            end

            m_eg = (m_win >= 0) ? 3'(1 << m_win) : 3'b000;
            chk("gnt", gnt_o, m_eg);
            chk("mem_we", mem_we, (m_win >= 0) ? we_i[m_win] : 1'b0);
            chk("mem_addr", mem_addr, (m_win >= 0) ? addr_i[m_win] : 16'h0);
            chk("mem_wdata", mem_wdata, (m_win >= 0) ? wdata_i[m_win] : 8'h0);

            m_last_gnt = m_eg;
            m_rv = '0;
            if (m_win >= 0) begin
                m_own_out = m_win;
                if (we_i[m_win]) mm[addr_i[m_win]] = wdata_i[m_win];
                else begin m_rv = m_eg; m_rv_data = mm[addr_i[m_win]]; end
            end
        end
    end

    task automatic cyc(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
        @(posedge clk); #1;
        req_i = r; we_i = w; lock_i = l;
        @(negedge clk); #1;
    endtask

    logic [2:0] rr_exp [6];
    logic [2:0] lk_exp [6];

    initial begin
        for (int a = 0; a < 65536; a++) begin mem[a] = '0; mm[a] = '0; end
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        lk_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
        rst_n = 1'b0; req_i = 3'b111; we_i = '0; lock_i = '0;
        for (int k = 0; k < 3; k++) begin addr_i[k] = 16'(k); wdata_i[k] = '0; end

        // reset with everyone requesting
        for (int i = 0; i < 3; i++) begin
            cyc(3'b111, 3'b000, 3'b000);
            chk("reset_gnt", gnt_o, 3'b000);
            chk("reset_rvalid", rvalid_o, 3'b000);
            chk("reset_mem_we", mem_we, 1'b0);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); #1;

        // round-robin with all requesters holding reads
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(3'b111, 3'b000, 3'b000);
            chk("rr_seq", gnt_o, rr_exp[i]);
            if (i > 0) chk("rr_rvalid", rvalid_o, rr_exp[i-1]);
        end

        // host write then fetch read of the same byte
        cyc(3'b000, 3'b000, 3'b000);
        addr_i[2] = 16'h0100; wdata_i[2] = 8'h5A; addr_i[0] = 16'h0100;
        cyc(3'b100, 3'b100, 3'b000);
        chk("wr_gnt", gnt_o, 3'b100);
        chk("wr_mem_we", mem_we, 1'b1);
        cyc(3'b001, 3'b000, 3'b000);
        chk("rd_gnt", gnt_o, 3'b001);
        chk("wr_no_rvalid", rvalid_o, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        chk("rd_rvalid", rvalid_o, 3'b001);
        chk("rd_rdata", rdata_o, 8'h5A);

        // exec locked burst against a waiting fetch: forced rotation
        for (int i = 0; i < 6; i++) begin
            cyc((i < 5) ? 3'b011 : 3'b010, 3'b000, 3'b010);
            chk("lock_rot", gnt_o, lk_exp[i]);
        end
        cyc(3'b010, 3'b000, 3'b000);
        chk("lock_end", gnt_o, 3'b010);
        cyc(3'b000, 3'b000, 3'b000);

        // uncontested burst past MAX_BURST, then release by dropping req
        for (int i = 0; i < 20; i++) begin
            cyc(3'b010, 3'b000, 3'b010);
            chk("burst20", gnt_o, 3'b010);
        end
        cyc(3'b100, 3'b000, 3'b000);
        chk("drop_nogrant", gnt_o, 3'b000);
        cyc(3'b100, 3'b000, 3'b000);
        chk("drop_host", gnt_o, 3'b100);
        cyc(3'b000, 3'b000, 3'b000);

        // random traffic; requesters hold until granted
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 499) != 0);
            for (int k = 0; k < 3; k++) begin
                if (!(req_i[k] && !m_last_gnt[k])) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_i[k]   = 1'b1;
                        we_i[k]    = 1'($urandom_range(0, 1));
                        lock_i[k]  = 1'($urandom_range(0, 1));
                        addr_i[k]  = 16'($urandom_range(0, 15));
                        wdata_i[k] = 8'($urandom);
                    end else begin
                        req_i[k] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk); #1;
        req_i = '0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
